// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move controller and win validator.
package ttt_pkg;

  localparam int NUM_CELLS = 9;
  localparam int CELL_W    = 2;
  localparam int BOARD_W   = NUM_CELLS * CELL_W;
  localparam int CNT_W     = 4;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    PX    = 2'b01,
    PO    = 2'b10
  } cell_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MOVE,
    CHECK,
    DONE
  } state_t;

  // The opponent of the given player; anything that is not X hands the turn to X.
  function automatic cell_t other_player(input cell_t p);
    return (p == PX) ? PO : PX;
  endfunction

endpackage

// File: rtl/ttt_first_empty.sv
// Combinational priority encoder: lowest-index empty cell of the board and a found flag.
module ttt_first_empty
  import ttt_pkg::*;
(
  input  logic [BOARD_W-1:0] i_board,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_found
);

  // Scan from the highest cell down so the lowest empty index is the last one written.
  always_comb begin
    // NOTE: every output of a combinational block gets a value before any branch, otherwise a latch is inferred.
    o_idx   = '0;
    o_found = 1'b0;
    for (int k = NUM_CELLS - 1; k >= 0; k--) begin
      if (i_board[k*CELL_W +: CELL_W] == EMPTY) begin
        o_idx   = IDX_W'(k);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttt_move_ctrl.sv
// Tic-tac-toe move controller: validates and places moves, alternates players, counts moves
// and ends the game on the validator's win flag or a full board.
// Optional feature: define TTT_TURN_TIMER_EN to add a per-turn timer that places an
// automatic move in the lowest empty cell after TURN_CYCLES idle cycles.
module ttt_move_ctrl
  import ttt_pkg::*;
#(
  parameter int TURN_CYCLES = 50_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 move_valid,
  input  logic [3:0]           move_cell,
  input  logic                 win_i,
  output logic [BOARD_W-1:0]   board_o,
  output logic [1:0]           player_o,
  output logic                 move_ack,
  output logic                 move_err,
  output logic                 timeout_o,
  output logic                 game_over,
  output logic [1:0]           winner_o
);

  state_t               r_state, w_state_nx;
  logic [BOARD_W-1:0]   r_board, w_board_nx;
  cell_t                r_player, w_player_nx;
  logic [CNT_W-1:0]     r_count, w_count_nx;
  logic [1:0]           r_winner, w_winner_nx;
  logic                 r_ack, w_ack_nx;
  logic                 r_err, w_err_nx;
  logic                 r_timeout, w_timeout_nx;

  logic                 w_cell_in_range;
  logic                 w_cell_empty;
  logic                 w_legal;
  logic                 w_expired;
  logic [IDX_W-1:0]     w_empty_idx;
  logic                 w_wr_en;
  logic [IDX_W-1:0]     w_wr_idx;

`ifdef TTT_TURN_TIMER_EN
  localparam int TMR_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

  logic [TMR_W-1:0] r_timer, w_timer_nx;
  logic             w_empty_found;

  ttt_first_empty u_first_empty (
    .i_board (r_board),
    .o_idx   (w_empty_idx),
    .o_found (w_empty_found)
  );

  assign w_expired = (r_state == WAIT_MOVE) && !start && w_empty_found &&
                     (r_timer == TMR_W'(TURN_CYCLES - 1));

  // Timer runs only while staying in WAIT_MOVE; any entry or restart starts it from zero.
  always_comb begin
    w_timer_nx = '0;
    if ((r_state == WAIT_MOVE) && (w_state_nx == WAIT_MOVE) && !start) begin
      w_timer_nx = r_timer + TMR_W'(1);
    end
  end

  // Turn timer register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_timer <= '0;
    end else begin
      r_timer <= w_timer_nx;
    end
  end
`else
  logic w_unused_turn_cycles;

  assign w_unused_turn_cycles = (TURN_CYCLES != 0);
  assign w_expired            = 1'b0;
  assign w_empty_idx          = '0;
`endif

  // Decode the requested cell: in range and currently empty.
  always_comb begin
    w_cell_in_range = 1'b0;
    w_cell_empty    = 1'b0;
    for (int k = 0; k < NUM_CELLS; k++) begin
      if (move_cell == 4'(k)) begin
        w_cell_in_range = 1'b1;
        w_cell_empty    = (r_board[k*CELL_W +: CELL_W] == EMPTY);
      end
    end
  end

  assign w_legal = move_valid && w_cell_in_range && w_cell_empty;

  // Next-state, board update and pulse generation; start overrides everything.
  always_comb begin
    w_state_nx   = r_state;
    w_board_nx   = r_board;
    w_player_nx  = r_player;
    w_count_nx   = r_count;
    w_winner_nx  = r_winner;
    w_ack_nx     = 1'b0;
    w_err_nx     = 1'b0;
    w_timeout_nx = 1'b0;
    w_wr_en      = 1'b0;
    w_wr_idx     = move_cell;

    if (start) begin
      w_state_nx  = WAIT_MOVE;
      w_board_nx  = '0;
      w_player_nx = PX;
      w_count_nx  = '0;
      w_winner_nx = 2'b00;
    end else begin
      unique case (r_state)
        IDLE: begin
        end
        WAIT_MOVE: begin
          if (w_legal) begin
            w_wr_en    = 1'b1;
            w_ack_nx   = 1'b1;
            w_state_nx = CHECK;
          end else if (w_expired) begin
            // An illegal request on the expiry cycle is dropped silently in favour of the auto-move.
            w_wr_en      = 1'b1;
            w_wr_idx     = w_empty_idx;
            w_timeout_nx = 1'b1;
            w_state_nx   = CHECK;
          end else if (move_valid) begin
            w_err_nx = 1'b1;
          end
        end
        CHECK: begin
          if (win_i) begin
            w_winner_nx = r_player;
            w_state_nx  = DONE;
          end else if (r_count == CNT_W'(NUM_CELLS)) begin
            w_winner_nx = 2'b00;
            w_state_nx  = DONE;
          end else begin
            w_player_nx = other_player(r_player);
            w_state_nx  = WAIT_MOVE;
          end
        end
        DONE: begin
        end
        default: begin
          w_state_nx = IDLE;
        end
      endcase
    end

    if (w_wr_en) begin
      for (int k = 0; k < NUM_CELLS; k++) begin
        if (w_wr_idx == IDX_W'(k)) begin
          w_board_nx[k*CELL_W +: CELL_W] = r_player;
        end
      end
      if (r_count < CNT_W'(NUM_CELLS)) begin
        w_count_nx = r_count + CNT_W'(1);
      end
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      r_state   <= IDLE;
      r_board   <= '0;
      r_player  <= PX;
      r_count   <= '0;
      r_winner  <= 2'b00;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_board   <= w_board_nx;
      r_player  <= w_player_nx;
      r_count   <= w_count_nx;
      r_winner  <= w_winner_nx;
      r_ack     <= w_ack_nx;
      r_err     <= w_err_nx;
      r_timeout <= w_timeout_nx;
    end
  end

  assign board_o   = r_board;
  assign player_o  = r_player;
  assign move_ack  = r_ack;
  assign move_err  = r_err;
  assign timeout_o = r_timeout;
  assign game_over = (r_state == DONE);
  assign winner_o  = r_winner;

endmodule

// File: tb/tb_ttt_move_ctrl.sv
// Directed self-checking bench for ttt_move_ctrl with a behavioural win validator.
// Timer scenarios run when TTT_TURN_TIMER_EN is defined (TURN_CYCLES overridden to 8).
module tb_ttt_move_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic        move_valid;
  logic [3:0]  move_cell;
  logic        win_i;
  logic [17:0] board_o;
  logic [1:0]  player_o;
  logic        move_ack;
  logic        move_err;
  logic        timeout_o;
  logic        game_over;
  logic [1:0]  winner_o;

  int checks   = 0;
  int failures = 0;

  ttt_move_ctrl #(.TURN_CYCLES(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .move_valid (move_valid),
    .move_cell  (move_cell),
    .win_i      (win_i),
    .board_o    (board_o),
    .player_o   (player_o),
    .move_ack   (move_ack),
    .move_err   (move_err),
    .timeout_o  (timeout_o),
    .game_over  (game_over),
    .winner_o   (winner_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural win validator: any line of three equal non-empty cells.
  function automatic logic line3(input logic [17:0] b, input int a, input int c, input int d);
    logic [1:0] x, y, z;
    x = b[a*2 +: 2];
    y = b[c*2 +: 2];
    z = b[d*2 +: 2];
    return (x != 2'b00) && (x == y) && (y == z);
  endfunction

  always_comb begin
    win_i = line3(board_o, 0, 1, 2) || line3(board_o, 3, 4, 5) || line3(board_o, 6, 7, 8) ||
            line3(board_o, 0, 3, 6) || line3(board_o, 1, 4, 7) || line3(board_o, 2, 5, 8) ||
            line3(board_o, 0, 4, 8) || line3(board_o, 2, 4, 6);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // One move request: pulses checked one cycle after the request edge, then one more cycle for CHECK.
  task automatic play(input logic [3:0] c, input logic legal, input string tag);
    move_valid = 1'b1;
    move_cell  = c;
    tick();
    move_valid = 1'b0;
    check({tag, "_ack"}, 32'(move_ack), 32'(legal));
    check({tag, "_err"}, 32'(move_err), 32'(!legal));
    tick();
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    move_valid = 1'b0;
    move_cell  = 4'd0;

    // Power-on reset.
    tick();
    tick();
    check("rst_board", 32'(board_o), 32'h0);
    check("rst_player", 32'(player_o), 32'h1);
    check("rst_over", 32'(game_over), 32'h0);
    check("rst_winner", 32'(winner_o), 32'h0);
    check("rst_pulses", {29'd0, move_ack, move_err, timeout_o}, 32'h0);
    reset = 1'b1;

    // Reset mid-game abandons the game.
    do_start();
    check("start_player", 32'(player_o), 32'h1);
    play(4'd4, 1'b1, "mid_x4");
    check("mid_board", 32'(board_o), 32'h100);
    check("mid_player", 32'(player_o), 32'h2);
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check("midrst_board", 32'(board_o), 32'h0);
    check("midrst_player", 32'(player_o), 32'h1);
    check("midrst_over", 32'(game_over), 32'h0);
    check("midrst_pulses", {29'd0, move_ack, move_err, timeout_o}, 32'h0);

    // X wins on the top row.
    do_start();
    play(4'd0, 1'b1, "w_x0");
    play(4'd3, 1'b1, "w_o3");
    play(4'd1, 1'b1, "w_x1");
    play(4'd4, 1'b1, "w_o4");
    check("w_not_over", 32'(game_over), 32'h0);
    play(4'd2, 1'b1, "w_x2");
    check("w_over", 32'(game_over), 32'h1);
    check("w_winner", 32'(winner_o), 32'h1);
    check("w_row", 32'(board_o[5:0]), 32'h15);
    check("w_board", 32'(board_o), 32'h295);
    check("w_player", 32'(player_o), 32'h1);

    // DONE ignores move requests, then start restarts.
    move_valid = 1'b1;
    move_cell  = 4'd5;
    tick();
    move_valid = 1'b0;
    check("done_pulses", {30'd0, move_ack, move_err}, 32'h0);
    check("done_board", 32'(board_o), 32'h295);
    check("done_over", 32'(game_over), 32'h1);
    do_start();
    check("restart_board", 32'(board_o), 32'h0);
    check("restart_player", 32'(player_o), 32'h1);
    check("restart_over", 32'(game_over), 32'h0);
    check("restart_winner", 32'(winner_o), 32'h0);
    play(4'd8, 1'b1, "restart_x8");
    check("restart_b8", 32'(board_o), 32'h10000);

    // Occupied and out-of-range cells.
    do_start();
    play(4'd4, 1'b1, "il_x4");
    check("il_player_o", 32'(player_o), 32'h2);
    play(4'd4, 1'b0, "il_o4");
    check("il_board", 32'(board_o), 32'h100);
    check("il_player", 32'(player_o), 32'h2);
    play(4'd9, 1'b0, "il_cell9");
    play(4'd15, 1'b0, "il_cell15");
    check("il_board2", 32'(board_o), 32'h100);

    // Full-board draw.
    do_start();
    play(4'd4, 1'b1, "d_x4");
    play(4'd0, 1'b1, "d_o0");
    play(4'd2, 1'b1, "d_x2");
    play(4'd6, 1'b1, "d_o6");
    play(4'd3, 1'b1, "d_x3");
    play(4'd5, 1'b1, "d_o5");
    play(4'd1, 1'b1, "d_x1");
    play(4'd7, 1'b1, "d_o7");
    check("d_not_over8", 32'(game_over), 32'h0);
    play(4'd8, 1'b1, "d_x8");
    check("d_over", 32'(game_over), 32'h1);
    check("d_winner", 32'(winner_o), 32'h0);
    check("d_board", 32'(board_o), 32'h1A956);
    check("d_player", 32'(player_o), 32'h1);

`ifdef TTT_TURN_TIMER_EN
    // Automatic moves after 8 idle WAIT_MOVE cycles.
    do_start();
    for (int i = 0; i < 7; i++) tick();
    check("t_not_yet", 32'(timeout_o), 32'h0);
    tick();
    check("t_x_timeout", 32'(timeout_o), 32'h1);
    check("t_x_board", 32'(board_o), 32'h1);
    tick();
    check("t_x_pulse_end", 32'(timeout_o), 32'h0);
    check("t_o_player", 32'(player_o), 32'h2);
    for (int i = 0; i < 8; i++) tick();
    check("t_o_timeout", 32'(timeout_o), 32'h1);
    check("t_o_board", 32'(board_o), 32'h9);
    tick();
    check("t_x2_player", 32'(player_o), 32'h1);
    // Legal move on the expiry cycle wins over the auto-move.
    for (int i = 0; i < 7; i++) tick();
    move_valid = 1'b1;
    move_cell  = 4'd5;
    tick();
    move_valid = 1'b0;
    check("t_legal_ack", 32'(move_ack), 32'h1);
    check("t_legal_to", 32'(timeout_o), 32'h0);
    check("t_legal_board", 32'(board_o), 32'h409);
    tick();
    // Illegal move on the expiry cycle: auto-move, no error.
    for (int i = 0; i < 7; i++) tick();
    move_valid = 1'b1;
    move_cell  = 4'd5;
    tick();
    move_valid = 1'b0;
    check("t_illegal_to", 32'(timeout_o), 32'h1);
    check("t_illegal_err", 32'(move_err), 32'h0);
    check("t_illegal_board", 32'(board_o), 32'h429);
    tick();
`else
    // Without the timer a turn waits indefinitely.
    do_start();
    for (int i = 0; i < 20; i++) tick();
    check("nt_timeout", 32'(timeout_o), 32'h0);
    check("nt_board", 32'(board_o), 32'h0);
    check("nt_player", 32'(player_o), 32'h1);
    play(4'd0, 1'b1, "nt_x0");
    check("nt_board2", 32'(board_o), 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
